// File: rtl/ones_comp_checksum_ctrl_pkg.sv
// Shared definitions for the ones'-complement checksum controller:
// FSM state encodings and default datapath widths.
package ones_comp_checksum_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ones_comp_checksum_ctrl_if.sv
// Handshake/result bundle between the word source, the checksum controller
// and the result consumer. The master side is the source/consumer, the slave
// side is the controller.
interface ones_comp_checksum_ctrl_if
  import ones_comp_checksum_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] checksum;
  logic [CNT_W-1:0] word_count;
  logic             ok;

  modport master (
    output start, in_valid, in_data, in_last, out_ready,
    input  in_ready, busy, out_valid, checksum, word_count, ok
  );

  modport slave (
    input  start, in_valid, in_data, in_last, out_ready,
    output in_ready, busy, out_valid, checksum, word_count, ok
  );

endinterface

// File: rtl/ones_comp_checksum_ctrl_add.sv
// Combinational ones'-complement adder: the carry-out of the plain sum is
// folded back into bit 0. One fold always suffices because the largest
// folded value is 2^WIDTH-1.
module ones_comp_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH:0] w_raw;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = w_raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_raw[WIDTH]};

endmodule

// File: rtl/ones_comp_checksum_ctrl.sv
// Streaming ones'-complement checksum controller (IDLE -> ACCUM -> DONE).
// Accumulates a burst of words with end-around carry and presents the
// complemented accumulator as the checksum.
// Optional feature macro: ONES_COMP_CKSUM_VERIFY_EN -- when defined, ok is
// registered high on entry to DONE if the final accumulator is all-ones;
// otherwise ok is tied low.
module ones_comp_checksum_ctrl
  import ones_comp_checksum_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                     clk,
  input logic                     rst_n,
  ones_comp_checksum_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_wordCount;
  logic [WIDTH-1:0] w_accSum;
  logic             w_startAccept;
  logic             w_accept;

  assign w_startAccept = (r_state == ST_IDLE) && bus.start;
  assign w_accept      = (r_state == ST_ACCUM) && bus.in_valid;

  ones_comp_add #(.WIDTH(WIDTH)) u_add (
    .i_a   (r_acc),
    .i_b   (bus.in_data),
    .o_sum (w_accSum)
  );

  // State register; reset drops straight back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state logic and handshake decode from registered state only
  always_comb begin
    w_stateNext   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_stateNext = ST_ACCUM;
      end
      ST_ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Accumulator and saturating word counter, cleared on an honoured start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_wordCount <= '0;
    end else if (w_startAccept) begin
      r_acc       <= '0;
      r_wordCount <= '0;
    end else if (w_accept) begin
      r_acc <= w_accSum;
      if (r_wordCount != {CNT_W{1'b1}}) r_wordCount <= r_wordCount + CNT_W'(1);
    end
  end

  assign bus.checksum   = ~r_acc;
  assign bus.word_count = r_wordCount;

`ifdef ONES_COMP_CKSUM_VERIFY_EN
  logic r_ok;

  // Capture the verify result with the final word; held until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_ok <= 1'b0;
    else if (w_startAccept)          r_ok <= 1'b0;
    else if (w_accept && bus.in_last) r_ok <= (w_accSum == {WIDTH{1'b1}});
  end

  assign bus.ok = r_ok;
`else
  assign bus.ok = 1'b0;
`endif

endmodule

// File: tb/tb_ones_comp_checksum_ctrl.sv
// Directed bench for ones_comp_checksum_ctrl with a result scoreboard.
// Expected checksum/count/ok are computed by a small arithmetic model when
// words are driven and popped when the controller presents its result.
module tb_ones_comp_checksum_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [WIDTH-1:0] cks;
    logic [CNT_W-1:0] cnt;
    logic             ok;
  } exp_t;

  logic clk;
  logic rst_n;

  ones_comp_checksum_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ones_comp_checksum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   nVectors    = 0;
  int   nMiscompares = 0;
  exp_t sbQ[$];
  int   mAcc;
  int   mCount;

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic startBurst();
    @(negedge clk);
    checkOutput("idleReady", 32'(bus.in_ready), 32'd0);
    checkOutput("idleBusy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    mAcc   = 0;
    mCount = 0;
    @(negedge clk);
    checkOutput("startReady", 32'(bus.in_ready), 32'd1);
    checkOutput("startBusy", 32'(bus.busy), 32'd1);
  endtask

  // Drive one word, optionally preceded by idle gaps that also present a
  // stray in_last which must be ignored.
  task automatic applyStimulus(input int data, input bit last, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b1;
      checkOutput("gapReady", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_last = 1'b0;
    end
    @(negedge clk);
    if (gaps == 0) checkOutput("wordReady", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(data);
    bus.in_last  = last;
    mAcc = mAcc + data;
    if (mAcc > MASK) mAcc = mAcc - MASK;
    if (mCount < CMAX) mCount++;
    if (last) begin
      exp_t e;
      e.cks = WIDTH'(~mAcc);
      e.cnt = CNT_W'(mCount);
`ifdef ONES_COMP_CKSUM_VERIFY_EN
      e.ok  = (mAcc == MASK);
`else
      e.ok  = 1'b0;
`endif
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Expect the result the cycle after the last word, hold it for holdCycles
  // (pulsing start if asked), then release it and check the return to IDLE.
  task automatic collectResult(input int holdCycles, input bit pulseStart);
    exp_t e;
    @(negedge clk);
    checkOutput("outValid", 32'(bus.out_valid), 32'd1);
    checkOutput("doneReady", 32'(bus.in_ready), 32'd0);
    checkOutput("sbPending", 32'(sbQ.size() != 0), 32'd1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    checkOutput("checksum", 32'(bus.checksum), 32'(e.cks));
    checkOutput("wordCount", 32'(bus.word_count), 32'(e.cnt));
    checkOutput("ok", 32'(bus.ok), 32'(e.ok));
    for (int h = 0; h < holdCycles; h++) begin
      bus.start = pulseStart;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
      checkOutput("holdChecksum", 32'(bus.checksum), 32'(e.cks));
      checkOutput("holdCount", 32'(bus.word_count), 32'(e.cnt));
      checkOutput("holdOk", 32'(bus.ok), 32'(e.ok));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("releaseValid", 32'(bus.out_valid), 32'd0);
    checkOutput("releaseBusy", 32'(bus.busy), 32'd0);
    checkOutput("retainChecksum", 32'(bus.checksum), 32'(e.cks));
    checkOutput("retainCount", 32'(bus.word_count), 32'(e.cnt));
  endtask

  // Linear directed sequence
  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    mAcc          = 0;
    mCount        = 0;

    #12;
    checkOutput("rstReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstChecksum", 32'(bus.checksum), 32'hF);
    checkOutput("rstCount", 32'(bus.word_count), 32'd0);
    checkOutput("rstOk", 32'(bus.ok), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] burst 0x3, 0x4");
    startBurst();
    applyStimulus(3, 1'b0, 0);
    applyStimulus(4, 1'b1, 0);
    collectResult(0, 1'b0);

    $display("[TB] burst 0xF, 0x1 (end-around carry)");
    startBurst();
    applyStimulus(15, 1'b0, 0);
    applyStimulus(1, 1'b1, 0);
    collectResult(0, 1'b0);

    $display("[TB] burst 0x9, 0x8 with gaps");
    startBurst();
    applyStimulus(9, 1'b0, 0);
    applyStimulus(8, 1'b1, 3);
    collectResult(0, 1'b0);

    $display("[TB] burst 0x3, 0x4, 0x8 (negative zero, verifies)");
    startBurst();
    applyStimulus(3, 1'b0, 0);
    applyStimulus(4, 1'b0, 0);
    applyStimulus(8, 1'b1, 0);
    collectResult(5, 1'b1);

    $display("[TB] burst 0x3, 0x4, 0x9 (corrupted)");
    startBurst();
    applyStimulus(3, 1'b0, 0);
    applyStimulus(4, 1'b0, 0);
    applyStimulus(9, 1'b1, 0);
    collectResult(0, 1'b0);

    $display("[TB] long burst, counter saturation");
    startBurst();
    for (int i = 0; i < 259; i++) applyStimulus(i % 16, 1'b0, 0);
    applyStimulus(5, 1'b1, 0);
    collectResult(0, 1'b0);

    $display("[TB] reset mid-burst");
    startBurst();
    applyStimulus(6, 1'b0, 0);
    applyStimulus(7, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstReady", 32'(bus.in_ready), 32'd0);
    checkOutput("midRstCount", 32'(bus.word_count), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    mAcc   = 0;
    mCount = 0;
    @(negedge clk);
    checkOutput("rstStartReady", 32'(bus.in_ready), 32'd1);
    applyStimulus(1, 1'b1, 0);
    collectResult(0, 1'b0);

    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
